// File: rtl/cfg_types_pkg.sv
// Shared types and limits for the accelerator control path: FSM states,
// error codes, the maximum transfer length and the length-validity check.
package cfg_types_pkg;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } acc_state_t;

  typedef enum logic [1:0] {
    ER_OKAY        = 2'd0,
    ER_INVALID_CFG = 2'd1,
    ER_OTHERS      = 2'd2
  } acc_error_t;

  // A job length is usable when it is non-zero and fits the core buffers.
  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/acc_beat_cnt.sv
// Beat counter for one stream direction: latches the job length on load,
// counts accepted beats and flags the beat that completes the transfer.
module acc_beat_cnt
  import cfg_types_pkg::*;
#(
  parameter int W = LEN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_len,
  input  logic         clear,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] len_q;
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      count <= '0;
    end else if (load) begin
      len_q <= load_len;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // Asserted combinationally during the beat after which count reaches len.
  assign last = en && ((count + W'(1)) == len_q);

endmodule

// File: rtl/acc_ctrl_fsm.sv
// Accelerator job controller: streams len_in words to the core, waits for
// completion, streams len_out words back. Optional WAIT timeout: ACC_CTRL_TIMEOUT_EN.
module acc_ctrl_fsm
  import cfg_types_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              ack_i,
  input  logic [LEN_W-1:0]  len_in_i,
  input  logic [LEN_W-1:0]  len_out_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              core_wr_valid_o,
  output logic [DATA_W-1:0] core_wr_data_o,
  input  logic              core_wr_ready_i,
  input  logic              core_done_i,
  input  logic              core_rd_valid_i,
  input  logic [DATA_W-1:0] core_rd_data_i,
  output logic              core_rd_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output acc_state_t        state_o,
  output acc_error_t        error_o,
  output logic              busy_o,
  output logic              done_o
);

  acc_state_t state, state_next;
  acc_error_t error, error_next;
  logic       load, clear_cnt;
  logic       wr_beat, rd_beat, wr_last, rd_last;
  logic       timeout;

  assign wr_beat = (state == ST_WRITE) && in_valid_i && core_wr_ready_i;
  assign rd_beat = (state == ST_READ) && core_rd_valid_i && out_ready_i;

  acc_beat_cnt #(.W(LEN_W)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_len (len_in_i),
    .clear    (clear_cnt),
    .en       (wr_beat),
    .last     (wr_last)
  );

  acc_beat_cnt #(.W(LEN_W)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_len (len_out_i),
    .clear    (clear_cnt),
    .en       (rd_beat),
    .last     (rd_last)
  );

`ifdef ACC_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != ST_WAIT)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  assign timeout = (state == ST_WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // The timeout length has no effect when the timeout is compiled out.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      error <= ER_OKAY;
    end else begin
      state <= state_next;
      error <= error_next;
    end
  end

  // Abort outranks every other exit from the busy states.
  always_comb begin
    state_next = state;
    error_next = error;
    load       = 1'b0;
    clear_cnt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (len_ok(len_in_i) && len_ok(len_out_i)) begin
            state_next = ST_WRITE;
            error_next = ER_OKAY;
            load       = 1'b1;
          end else begin
            state_next = ST_DONE;
            error_next = ER_INVALID_CFG;
          end
        end
      end
      ST_WRITE: begin
        if (abort_i) begin
          state_next = ST_DONE;
          error_next = ER_OTHERS;
        end else if (wr_last) begin
          state_next = ST_WAIT;
          clear_cnt  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort_i) begin
          state_next = ST_DONE;
          error_next = ER_OTHERS;
        end else if (core_done_i) begin
          state_next = ST_READ;
        end else if (timeout) begin
          state_next = ST_DONE;
          error_next = ER_OTHERS;
        end
      end
      ST_READ: begin
        if (abort_i) begin
          state_next = ST_DONE;
          error_next = ER_OTHERS;
        end else if (rd_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ack_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign core_wr_valid_o = (state == ST_WRITE) && in_valid_i;
  assign in_ready_o      = (state == ST_WRITE) && core_wr_ready_i;
  assign core_wr_data_o  = in_data_i;

  assign out_valid_o     = (state == ST_READ) && core_rd_valid_i;
  assign core_rd_ready_o = (state == ST_READ) && out_ready_i;
  assign out_data_o      = core_rd_data_i;

  assign state_o = state;
  assign error_o = error;
  assign busy_o  = (state == ST_WRITE) || (state == ST_WAIT) || (state == ST_READ);
  assign done_o  = (state == ST_DONE);

endmodule
